// File: rtl/irrigation_timer_controller_pkg.sv
// Shared state codes, digit geometry and preset field offsets for the valve countdown timer.
// The package holds no logic, so it adds no latency and no flow control.
package irrigation_timer_controller_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_PAUSE = 3'd2,
    ST_DONE  = 3'd3
  } state_t;

  localparam int          DIGIT_W       = 4;
  localparam logic [3:0]  UNITS_MAX     = 4'd9;
  localparam int          SEC_UNITS_LSB = 0;
  localparam int          SEC_TENS_LSB  = 4;
  localparam int          MIN_UNITS_LSB = 8;
  localparam int          MIN_TENS_LSB  = 12;

  function automatic logic preset_valid(input logic [15:0] p,
                                        input logic [3:0]  sec_tens_max,
                                        input logic [3:0]  min_tens_max);
    return (p[SEC_UNITS_LSB +: DIGIT_W] <= UNITS_MAX) &&
           (p[SEC_TENS_LSB  +: DIGIT_W] <= sec_tens_max) &&
           (p[MIN_UNITS_LSB +: DIGIT_W] <= UNITS_MAX) &&
           (p[MIN_TENS_LSB  +: DIGIT_W] <= min_tens_max) &&
           (p != 16'h0000);
  endfunction

endpackage

// File: rtl/irrigation_timer_controller_bcd_down_digit.sv
// One BCD down-counting digit: load has priority over decrement, wraps 0 -> MAX with a borrow.
// The new value appears one edge after load or enable; the digit never stalls.
module bcd_down_digit #(
  parameter logic [3:0] MAX = 4'd9
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_load,
  input  logic [3:0] i_load_value,
  input  logic       i_enable,
  output logic [3:0] o_q,
  output logic       o_borrow_out
);

  logic [3:0] r_q;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_q <= 4'd0;
    end else if (i_load) begin
      r_q <= i_load_value;
    end else if (i_enable) begin
      r_q <= (r_q == 4'd0) ? MAX : r_q - 4'd1;
    end
  end

  assign o_q          = r_q;
  assign o_borrow_out = i_enable && (r_q == 4'd0);

endmodule

// File: rtl/irrigation_timer_controller.sv
// Valve countdown controller: MM:SS preset loaded into four chained BCD digits, decremented on a 1 Hz tick.
// Start, pause, cancel and expiry all take effect on the next edge; done and error are one-cycle pulses.
module irrigation_timer_controller
  import irrigation_timer_controller_pkg::*;
#(
  parameter int SEC_TENS_MAX = 5,
  parameter int MIN_TENS_MAX = 5,
  parameter int AUTO_RELOAD  = 0
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_tick,
  input  logic        i_start,
  input  logic        i_pause,
  input  logic        i_cancel,
  input  logic [15:0] i_preset_bcd,
  output logic [15:0] o_time_bcd,
  output logic [2:0]  o_state,
  output logic        o_valve_on,
  output logic        o_done,
  output logic        o_error
);

  localparam logic [3:0] LP_ST_MAX = 4'(SEC_TENS_MAX);
  localparam logic [3:0] LP_MT_MAX = 4'(MIN_TENS_MAX);

  state_t      r_state, w_next;
  logic [15:0] r_preset;
  logic        r_done, r_error;
  logic        w_load, w_dec, w_store, w_enter_done, w_reject;
  logic [15:0] w_load_val;
  logic [15:0] w_time;
  logic [3:0]  w_borrow;

  always_comb begin
    w_next       = r_state;
    w_load       = 1'b0;
    w_load_val   = 16'h0000;
    w_dec        = 1'b0;
    w_store      = 1'b0;
    w_enter_done = 1'b0;
    w_reject     = 1'b0;
    if (i_cancel) begin
      w_next = ST_IDLE;
      w_load = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (i_start) begin
            if (preset_valid(i_preset_bcd, LP_ST_MAX, LP_MT_MAX)) begin
              w_next     = ST_RUN;
              w_load     = 1'b1;
              w_load_val = i_preset_bcd;
              w_store    = 1'b1;
            end else begin
              w_reject = 1'b1;
            end
          end else if ((r_state == ST_DONE) && (AUTO_RELOAD != 0)) begin
            w_next     = ST_RUN;
            w_load     = 1'b1;
            w_load_val = r_preset;
          end
        end
        ST_RUN: begin
          if (i_pause) begin
            w_next = ST_PAUSE;
          end else if (i_tick) begin
            w_dec = 1'b1;
            if (w_time == 16'h0001) begin
              w_next       = ST_DONE;
              w_enter_done = 1'b1;
            end
          end
        end
        ST_PAUSE: begin
          if (i_pause) w_next = ST_RUN;
        end
        default: begin
          // Corrupted state code: fall back to a safe idle with the count cleared.
          w_next = ST_IDLE;
          w_load = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state  <= ST_IDLE;
      r_preset <= 16'h0000;
      r_done   <= 1'b0;
      r_error  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= w_enter_done;
      r_error <= w_reject;
      if (w_store) r_preset <= i_preset_bcd;
    end
  end

  bcd_down_digit #(.MAX(UNITS_MAX)) u_sec_units (
    .i_clock(i_clock), .i_reset(i_reset), .i_load(w_load),
    .i_load_value(w_load_val[SEC_UNITS_LSB +: DIGIT_W]), .i_enable(w_dec),
    .o_q(w_time[SEC_UNITS_LSB +: DIGIT_W]), .o_borrow_out(w_borrow[0])
  );

  bcd_down_digit #(.MAX(LP_ST_MAX)) u_sec_tens (
    .i_clock(i_clock), .i_reset(i_reset), .i_load(w_load),
    .i_load_value(w_load_val[SEC_TENS_LSB +: DIGIT_W]), .i_enable(w_borrow[0]),
    .o_q(w_time[SEC_TENS_LSB +: DIGIT_W]), .o_borrow_out(w_borrow[1])
  );

  bcd_down_digit #(.MAX(UNITS_MAX)) u_min_units (
    .i_clock(i_clock), .i_reset(i_reset), .i_load(w_load),
    .i_load_value(w_load_val[MIN_UNITS_LSB +: DIGIT_W]), .i_enable(w_borrow[1]),
    .o_q(w_time[MIN_UNITS_LSB +: DIGIT_W]), .o_borrow_out(w_borrow[2])
  );

  // Expiry stops the count at 00:00, so this digit is never asked to borrow below zero.
  bcd_down_digit #(.MAX(LP_MT_MAX)) u_min_tens (
    .i_clock(i_clock), .i_reset(i_reset), .i_load(w_load),
    .i_load_value(w_load_val[MIN_TENS_LSB +: DIGIT_W]), .i_enable(w_borrow[2]),
    .o_q(w_time[MIN_TENS_LSB +: DIGIT_W]), .o_borrow_out(w_borrow[3])
  );

  assign o_time_bcd = w_time;
  assign o_state    = r_state;
  assign o_valve_on = (r_state == ST_RUN);
  assign o_done     = r_done;
  assign o_error    = r_error;

endmodule
